// File: rtl/divisor_pkg.sv
// Shared types for the divisor arbiter: FSM states, response error codes
// and the round-robin pointer advance.
package divisor_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    typedef enum logic [1:0] {ERR_OK, ERR_DIV0, ERR_TMO} div_err_t;

    function automatic int rr_next(input int id, input int n);
        return (id + 1 == n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/divisor_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around, reported both one-hot and as an index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_id
);

    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        grant_onehot = '0;
        grant_id     = '0;
        found        = 1'b0;
        idx          = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_id          = idx;
            end
        end
    end

endmodule

// File: rtl/divisor_arbiter.sv
// Shares one sequential divisor core among N_REQ requesters: round-robin grant,
// one division in flight, div-by-zero bypass and a START->DONE watchdog.
module divisor_arbiter
    import divisor_pkg::*;
#(
    parameter int tamanyo = 32,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*tamanyo-1:0]   req_num,
    input  logic [N_REQ*tamanyo-1:0]   req_den,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic [tamanyo-1:0]         rsp_coc,
    output logic [tamanyo-1:0]         rsp_res,
    output logic [1:0]                 rsp_err,
    output logic                       START,
    output logic [tamanyo-1:0]         NUMERADOR,
    output logic [tamanyo-1:0]         DENOMINADOR,
    input  logic [tamanyo-1:0]         COC,
    input  logic [tamanyo-1:0]         RES,
    input  logic                       DONE,
    output logic                       busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    arb_state_t state;
    div_err_t   err_q;

    logic [IW-1:0]                  rr_ptr, owner, grant_id;
    logic [N_REQ-1:0]               grant_oh;
    logic [CW-1:0]                  cnt;
    logic [N_REQ-1:0][tamanyo-1:0]  num_v, den_v;
    logic [tamanyo-1:0]             gnum, gden;

    assign num_v = req_num;
    assign den_v = req_den;
    assign gnum  = num_v[grant_id];
    assign gden  = den_v[grant_id];

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req          (req_valid),
        .ptr          (rr_ptr),
        .grant_onehot (grant_oh),
        .grant_id     (grant_id)
    );

    // Gated by RST so no handshake can be lost while the FSM is held in reset.
    assign req_ready = (state == IDLE && !RST) ? grant_oh : '0;
    assign busy      = (state != IDLE);
    assign rsp_err   = err_q;

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) rsp_valid[owner] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            cnt         <= '0;
            START       <= 1'b0;
            NUMERADOR   <= '0;
            DENOMINADOR <= '0;
            rsp_coc     <= '0;
            rsp_res     <= '0;
            err_q       <= ERR_OK;
        end else begin
            START <= 1'b0;
            case (state)
                IDLE: if (|req_valid) begin
                    owner <= grant_id;
                    if (gden == '0) begin
                        // Core is left alone: operands keep their old values.
                        rsp_coc <= '1;
                        rsp_res <= gnum;
                        err_q   <= ERR_DIV0;
                        state   <= RESP;
                    end else begin
                        NUMERADOR   <= gnum;
                        DENOMINADOR <= gden;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    START <= 1'b1;
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (DONE) begin
                        rsp_coc <= COC;
                        rsp_res <= RES;
                        err_q   <= ERR_OK;
                        state   <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_coc <= '0;
                        rsp_res <= '0;
                        err_q   <= ERR_TMO;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: if (rsp_ready[owner]) begin
                    rr_ptr <= IW'(rr_next(int'(owner), N_REQ));
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_arbiter.sv
// Directed + randomized bench for divisor_arbiter with a behavioural core stub
// and a round-robin / arithmetic reference model.
module tb_divisor_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic             CLK;
    logic             RST;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0]   req_num, req_den;
    logic [W-1:0]     rsp_coc, rsp_res, NUMERADOR, DENOMINADOR;
    logic [1:0]       rsp_err;
    logic             START, DONE, busy;
    logic [W-1:0]     COC = '0;
    logic [W-1:0]     RES = '0;
    logic             core_done = 1'b0;
    logic             inj_done;

    divisor_arbiter #(.tamanyo(W), .N_REQ(N), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_num(req_num), .req_den(req_den),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_coc(rsp_coc), .rsp_res(rsp_res), .rsp_err(rsp_err),
        .START(START), .NUMERADOR(NUMERADOR), .DENOMINADOR(DENOMINADOR),
        .COC(COC), .RES(RES), .DONE(DONE), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    // Core stub: random latency, optionally hangs (never raises DONE).
    bit       hang = 0;
    int       core_cnt = 0;
    int       done_cyc = -1;
    logic [W-1:0] cnum, cden;
    assign DONE = core_done | inj_done;

    always @(negedge CLK) begin
        core_done = 1'b0;
        if (RST) core_cnt = 0;
        else begin
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0 && !hang) begin
                    core_done = 1'b1;
                    COC = (cden == 0) ? '1 : cnum / cden;
                    RES = (cden == 0) ? cnum : cnum % cden;
                    done_cyc = cyc;
                end
            end
            if (START) begin
                cnum = NUMERADOR;
                cden = DENOMINADOR;
                core_cnt = $urandom_range(1, 10);
            end
        end
    end

    int nchecks = 0;
    int nerrors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    bit           pend [N];
    logic [W-1:0] pnum [N];
    logic [W-1:0] pden [N];
    int           ptr = 0;
    int           wait_cnt [N];
    int           max_wait = 0;

    function automatic int rr_pick();
        for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_num[i*W +: W]  = pnum[i];
            req_den[i*W +: W]  = pden[i];
        end
    endtask

    task automatic drive_edge();
        @(posedge CLK);
        #1;
    endtask

    // Serve the next request the model predicts, hold off rsp_ready for bp cycles.
    task automatic serve(input int bp, input bit hang_i, output int g);
        int hs_cyc, st_cyc, rsp_cyc, starts;
        logic [W-1:0] ec, er;
        logic [1:0]   ee;
        bit got, bad, bp_bad;
        hang = hang_i;
        g = rr_pick();
        if (g < 0) begin
            check("serve_nothing_pending", 1, 0);
            return;
        end
        if (pden[g] == 0) begin ec = '1; er = pnum[g]; ee = 2'd1; end
        else if (hang_i)  begin ec = '0; er = '0;      ee = 2'd2; end
        else begin ec = pnum[g] / pden[g]; er = pnum[g] % pden[g]; ee = 2'd0; end
        for (int i = 0; i < N; i++) if (pend[i] && i != g) begin
            wait_cnt[i]++;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
        wait_cnt[g] = 0;

        @(negedge CLK);
        check("grant", req_ready, 64'(1) << g);
        hs_cyc = cyc;
        drive_edge();
        pend[g] = 0;
        apply();

        starts = 0; st_cyc = -1; got = 0; bad = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge CLK);
            if (START) begin starts++; st_cyc = cyc; end
            if (req_ready != 0) bad = 1;
            if (rsp_valid != 0) got = 1;
        end
        rsp_cyc = cyc;
        check("rsp_seen", got, 1);
        check("rsp_valid", rsp_valid, 64'(1) << g);
        check("rsp_coc", rsp_coc, ec);
        check("rsp_res", rsp_res, er);
        check("rsp_err", rsp_err, ee);
        check("no_ready_while_busy", bad, 0);
        if (pden[g] == 0) begin
            check("div0_no_start", starts, 0);
            check("div0_latency", rsp_cyc, hs_cyc + 1);
        end else begin
            check("one_start", starts, 1);
            check("start_latency", st_cyc, hs_cyc + 2);
            if (hang_i) check("timeout_latency", rsp_cyc, st_cyc + TO);
            else        check("rsp_latency", rsp_cyc, done_cyc + 1);
        end

        bp_bad = 0;
        for (int k = 0; k < bp; k++) begin
            drive_edge();
            rsp_ready = ~(N'(1) << g);
            inj_done  = hang_i && (k == 1);
            @(negedge CLK);
            if (rsp_valid !== (N'(1) << g) || rsp_coc !== ec || rsp_res !== er ||
                rsp_err !== ee || req_ready !== '0 || busy !== 1'b1) bp_bad = 1;
        end
        if (bp > 0) check("backpressure_hold", bp_bad, 0);

        drive_edge();
        inj_done  = 1'b0;
        rsp_ready = N'(1) << g;
        @(negedge CLK);
        drive_edge();
        rsp_ready = '0;
        ptr = (g + 1) % N;
    endtask

    initial begin
        int g;
        bit seen, bad;
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int g;
        bit seen, bad;
        RST = 1'b1; rsp_ready = '0; inj_done = 1'b0;
        req_valid = '0; req_num = '0; req_den = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; pnum[i] = 0; pden[i] = 0; wait_cnt[i] = 0; end
        repeat (2) drive_edge();

        // Reset state
        @(negedge CLK);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_start", START, 0);
        check("rst_num", NUMERADOR, 0);
        check("rst_den", DENOMINADOR, 0);
        check("rst_coc", rsp_coc, 0);
        check("rst_res", rsp_res, 0);
        check("rst_err", rsp_err, 0);
        check("rst_busy", busy, 0);

        // Contention: all four valid while still in reset
        drive_edge();
        for (int i = 0; i < N; i++) begin pend[i] = 1; pnum[i] = 3*i + 1; pden[i] = 3; end
        apply();
        @(negedge CLK);
        check("rst_blocks_ready", req_ready, 0);
        drive_edge();
        RST = 1'b0;
        for (int i = 0; i < N; i++) begin
            serve(0, 0, g);
            check("contention_order", g, i);
            check("contention_coc", rsp_coc, i);
        end

        // Single request
        pend[0] = 1; pnum[0] = 100; pden[0] = 7; apply();
        serve(0, 0, g);
        check("single_coc_14", rsp_coc, 14);

        // Divide by zero on requester 2
        pend[2] = 1; pnum[2] = 55; pden[2] = 0; apply();
        serve(0, 0, g);

        // Timeout on requester 3, DONE injected during RESP and later in IDLE
        pend[3] = 1; pnum[3] = 1234; pden[3] = 5; apply();
        serve(3, 1, g);
        hang = 0;
        inj_done = 1'b1;
        @(negedge CLK);
        drive_edge();
        inj_done = 1'b0;
        @(negedge CLK);
        check("late_done_busy", busy, 0);
        check("late_done_rsp", rsp_valid, 0);
        check("late_done_start", START, 0);

        // Backpressure on requester 1 with others waiting
        drive_edge();
        pend[0] = 1; pnum[0] = 9; pden[0] = 2; apply();
        serve(0, 0, g);
        for (int i = 1; i < N; i++) begin pend[i] = 1; pnum[i] = 1000 + i; pden[i] = i + 1; end
        apply();
        serve(10, 0, g);
        check("bp_owner", g, 1);
        serve(0, 0, g);
        check("bp_next", g, 2);
        serve(0, 0, g);

        // Reset in WAIT: aborted request must never answer
        pend[1] = 1; pnum[1] = 1000; pden[1] = 9; apply();
        hang = 1;
        @(negedge CLK);
        check("abort_grant", req_ready, 64'(2));
        drive_edge();
        pend[1] = 0; apply();
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge CLK);
            if (START) seen = 1;
        end
        check("abort_start_seen", seen, 1);
        drive_edge();
        RST = 1'b1;
        drive_edge();
        RST = 1'b0;
        @(negedge CLK);
        check("abort_busy", busy, 0);
        check("abort_rsp", rsp_valid, 0);
        check("abort_start", START, 0);
        check("abort_num", NUMERADOR, 0);
        check("abort_err", rsp_err, 0);
        bad = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge CLK);
            if (rsp_valid != 0 || START || busy) bad = 1;
        end
        check("abort_quiet", bad, 0);
        ptr = 0;
        hang = 0;
        drive_edge();
        pend[1] = 1; pnum[1] = 77; pden[1] = 4; apply();
        serve(0, 0, g);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            bit any;
            any = 0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    pnum[i] = $urandom;
                    if ($urandom_range(0, 7) == 0) pden[i] = 0;
                    else begin
                        pden[i] = $urandom >> $urandom_range(0, 31);
                        if (pden[i] == 0) pden[i] = 1;
                    end
                end
                if (pend[i]) any = 1;
            end
            if (!any) begin pend[it % N] = 1; pnum[it % N] = $urandom; pden[it % N] = 3; end
            apply();
            serve($urandom_range(0, 3), 0, g);
        end
        check("fairness", max_wait <= N - 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
